// File: rtl/hotbuf_pkg.sv
// Shared types and default geometry for the hot row buffer.
package hotbuf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int LANES_DEF  = 256;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [1:0] {IDLE, BURST, LAST} state_e;

  typedef logic [LANES_DEF-1:0][DATA_W_DEF-1:0] row_t;
endpackage

// File: rtl/hotbuf_mem.sv
// Single-port row store: synchronous write, registered read; the read
// register doubles as the stream output data register.
module hotbuf_mem
  import hotbuf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           we,
  input  logic [AW-1:0]                  addr,
  input  logic [LANES-1:0][DATA_W-1:0]   wdata,
  output logic [LANES-1:0][DATA_W-1:0]   rdata
);
  logic [LANES-1:0][DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Only the read register is reset; row contents survive reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             rdata <= '0;
    else if (en && !we)   rdata <= mem[addr];
  end
endmodule

// File: rtl/hot_buffer_stream.sv
// Row buffer with a burst read engine streaming rows over valid/ready;
// writes take priority over read issue on the single storage port.
module hot_buffer_stream
  import hotbuf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  wr_idx,
  input  logic [LANES-1:0][DATA_W-1:0]   wr_data,
  input  logic                           rd_req,
  input  logic [AW-1:0]                  rd_start,
  input  logic [AW:0]                    rd_len,
  output logic                           rd_ack,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES-1:0][DATA_W-1:0]   out_data,
  output logic                           out_last,
  output logic                           rd_done
);
  state_e        state, state_nxt;
  logic [AW-1:0] addr;
  logic [AW:0]   rem;
  logic          issue, last_acc, zero_done_q;
  logic          req_go, req_zero;

  assign req_go   = rd_req && (rd_len != '0);
  assign req_zero = rd_req && (rd_len == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_go) state_nxt = BURST;
      BURST:   if (issue && rem == (AW+1)'(1)) state_nxt = LAST;
      LAST:    if (last_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue needs the port (no write) and a free output slot.
  always_comb begin
    rd_ack   = (state == IDLE);
    issue    = (state == BURST) && !wr_en && (!out_valid || out_ready);
    last_acc = (state == LAST) && out_valid && out_ready && out_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr        <= '0;
      rem         <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= (state == IDLE) && req_zero;
      if (state == IDLE && req_go) begin
        addr <= rd_start;
        rem  <= rd_len;
      end else if (issue) begin
        addr <= addr + AW'(1);
        rem  <= rem - (AW+1)'(1);
      end
      if (issue) begin
        out_valid <= 1'b1;
        out_last  <= (rem == (AW+1)'(1));
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign rd_done = zero_done_q || last_acc;

  hotbuf_mem #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (wr_en || issue),
    .we    (wr_en),
    .addr  (wr_en ? wr_idx : addr),
    .wdata (wr_data),
    .rdata (out_data)
  );
endmodule

// File: tb/tb_hot_buffer_stream.sv
// Directed plus randomized bench for hot_buffer_stream against a row-array model.
module tb_hot_buffer_stream;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int DP = 64;
  localparam int AW = 6;
  localparam int RW = DW*LN;

  typedef logic [LN-1:0][DW-1:0] trow_t;

  logic          clk, rst;
  logic          wr_en, rd_req, rd_ack, out_valid, out_ready, out_last, rd_done;
  logic [AW-1:0] wr_idx, rd_start;
  logic [AW:0]   rd_len;
  trow_t         wr_data, out_data;

  trow_t model [DP];
  int total = 0;
  int bad   = 0;

  hot_buffer_stream #(.DATA_W(DW), .LANES(LN), .DEPTH(DP), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_req(rd_req), .rd_start(rd_start), .rd_len(rd_len), .rd_ack(rd_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .rd_done(rd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic trow_t pat(int r);
    trow_t d;
    for (int i = 0; i < LN; i++) d[i] = DW'(r*1000 + i);
    return d;
  endfunction

  function automatic trow_t rnd_row();
    trow_t d;
    for (int i = 0; i < LN; i++) d[i] = $urandom;
    return d;
  endfunction

  task automatic write_row(input int r, input trow_t d);
    wr_en = 1'b1; wr_idx = AW'(r); wr_data = d;
    tick();
    model[r] = d;
    wr_en = 1'b0;
  endtask

  // mode 0: always ready; 1: ready low for cycles 2..4; 2: random ready + random
  // writes to rows outside the burst. exp_last < 0 skips the latency check.
  task automatic burst(input string tag, input int start, input int len, input int mode,
                       input int wr_at, input int wr_r, input trow_t wr_d, input int exp_last);
    int nb, cyc, last_cyc;
    logic hold_chk;
    trow_t held;
    rd_req = 1'b1; rd_start = AW'(start); rd_len = (AW+1)'(len);
    @(negedge clk);
    chk({tag, "_ack"}, RW'(rd_ack), RW'(1));
    tick();
    rd_req = 1'b0;
    nb = 0; cyc = 1; last_cyc = 0; hold_chk = 1'b0; held = '0;
    while (nb < len && cyc < 400) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(cyc >= 2 && cyc <= 4) : 1'($urandom_range(0, 1));
      wr_en = 1'b0;
      if (cyc == wr_at) begin
        wr_en = 1'b1; wr_idx = AW'(wr_r); wr_data = wr_d;
      end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
        wr_en = 1'b1; wr_idx = AW'((start + 40 + int'($urandom_range(0, 15))) % DP); wr_data = rnd_row();
      end
      @(negedge clk);
      if (hold_chk) begin
        chk({tag, "_hold_valid"}, RW'(out_valid), RW'(1));
        chk({tag, "_hold_data"}, out_data, held);
      end
      hold_chk = 1'b0;
      if (out_valid && out_ready) begin
        chk({tag, "_data"}, out_data, model[(start + nb) % DP]);
        chk({tag, "_last"}, RW'(out_last), RW'(nb == len - 1));
        chk({tag, "_done"}, RW'(rd_done), RW'(nb == len - 1));
        nb++;
        last_cyc = cyc;
      end else begin
        chk({tag, "_idle_done"}, RW'(rd_done), RW'(0));
        if (out_valid) begin
          hold_chk = 1'b1; held = out_data;
        end
      end
      tick();
      if (wr_en) model[wr_idx] = wr_data;
      wr_en = 1'b0;
      cyc++;
    end
    out_ready = 1'b1;
    chk({tag, "_beats"}, RW'(nb), RW'(len));
    if (exp_last >= 0) chk({tag, "_latency"}, RW'(last_cyc), RW'(exp_last));
    @(negedge clk);
    chk({tag, "_end_valid"}, RW'(out_valid), RW'(0));
    chk({tag, "_end_ack"}, RW'(rd_ack), RW'(1));
    tick();
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    rd_req = 1'b0; rd_start = '0; rd_len = '0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", RW'(out_valid), RW'(0));
    chk("rst_last",  RW'(out_last),  RW'(0));
    chk("rst_data",  out_data,       RW'(0));
    chk("rst_done",  RW'(rd_done),   RW'(0));
    chk("rst_ack",   RW'(rd_ack),    RW'(1));
    rst = 1'b1;
    tick();

    for (int r = 0; r < DP; r++) write_row(r, pat(r));

    burst("basic",   0, 4, 0, 0, 0, '0, 5);
    burst("wrap",   62, 4, 0, 0, 0, '0, 5);
    burst("stall",   0, 4, 1, 0, 0, '0, 8);
    burst("wrslip", 10, 6, 0, 4, 13, rnd_row(), 8);
    burst("full",    5, 64, 0, 0, 0, '0, 65);

    // Zero-length request: done one cycle later, never valid.
    rd_req = 1'b1; rd_start = 6'd7; rd_len = '0;
    @(negedge clk);
    chk("zero_ack", RW'(rd_ack), RW'(1));
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("zero_done", RW'(rd_done), RW'(1));
    chk("zero_valid", RW'(out_valid), RW'(0));
    tick();
    @(negedge clk);
    chk("zero_done_off", RW'(rd_done), RW'(0));
    chk("zero_valid2", RW'(out_valid), RW'(0));
    tick();

    // Reset mid-burst.
    rd_req = 1'b1; rd_start = '0; rd_len = 7'd8; out_ready = 1'b1;
    tick();
    rd_req = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("mrst_valid", RW'(out_valid), RW'(0));
    chk("mrst_ack",   RW'(rd_ack),    RW'(1));
    chk("mrst_done",  RW'(rd_done),   RW'(0));
    chk("mrst_data",  out_data,       RW'(0));
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_after_done", RW'(rd_done), RW'(0));
    tick();
    burst("post_rst", 0, 4, 0, 0, 0, '0, 5);

    for (int k = 0; k < 6; k++) begin
      int s, l;
      for (int j = 0; j < 4; j++) write_row(int'($urandom_range(0, DP-1)), rnd_row());
      s = int'($urandom_range(0, DP-1));
      l = int'($urandom_range(1, 24));
      burst("rand", s, l, 2, 0, 0, '0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hot_buffer_stream.md
# hot_buffer_stream

Parametrised row buffer holding DEPTH rows of LANES×DATA_W words, feeding the MLU array. It is the successor to the fixed 64×256×32 hot buffer. A single write port stores one full row per cycle. A burst read engine streams rd_len consecutive rows, wrapping modulo DEPTH, over a valid/ready output with backpressure. It sits between the DMA row loader and the MLU input distributor.

## Interface
- DATA_W, 32, bits per lane word
- LANES, 256, words per row
- DEPTH, 64, rows stored; power of two
- AW, $clog2(DEPTH), row index width (derived)
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write row wr_idx this cycle
- wr_idx  in  AW  write row index
- wr_data  in  LANES×DATA_W  row to store
- rd_req  in  1  burst request; taken only when rd_ack=1
- rd_start  in  AW  first row of burst
- rd_len  in  AW+1  rows in burst, 0..DEPTH
- rd_ack  out  1  combinational; high in IDLE
- out_valid  out  1  out_data holds a beat
- out_ready  in  1  consumer accepts beat
- out_data  out  LANES×DATA_W  row data
- out_last  out  1  beat is final of burst
- rd_done  out  1  one-cycle pulse at burst completion

## Operation
- Reset: out_valid=0, out_last=0, out_data=0, rd_done=0, state IDLE, address and remaining counters 0. Reset does not clear row contents. Reset mid-burst aborts the burst with no rd_done.
- Storage is single-port: one access per cycle. When a write and a read issue would happen in the same cycle, the write wins and the read issue slips one cycle.
- Write: when wr_en=1, wr_data is stored to row wr_idx at the clock edge, in any state.
- FSM IDLE → BURST → LAST → IDLE.
  - IDLE: rd_ack=1. On rd_req with rd_len≥1, latch addr=rd_start and rem=rd_len, then go to BURST. On rd_req with rd_len=0, pulse rd_done next cycle and stay in IDLE.
  - BURST: a read is issued when wr_en=0 and the output slot is free (!out_valid || out_ready). On issue, addr=(addr+1) mod DEPTH and rem decrements. Issuing the beat where rem=1 moves the FSM to LAST.
  - LAST: no further issues. Return to IDLE in the cycle the out_last beat is accepted. rd_done pulses in that same cycle.
- Output register: an issued read loads out_data, sets out_valid=1, and sets out_last=(rem==1). While out_valid && !out_ready, out_data and out_last hold. out_valid clears after acceptance when no new issue occurs.
- Coherency: a read issued in cycle N returns contents as of the end of cycle N-1. A write to a row not yet issued in the current burst is visible to that burst.
- rd_len=DEPTH reads every row exactly once, starting at rd_start.

## Timing
- rd_req accepted at edge T, with no writes and out_ready held high:
  - first issue in cycle T+1
  - first out_valid in cycle T+2
  - one beat per cycle after that
  - last beat and rd_done in cycle T+1+rd_len
- Each cycle with wr_en=1 during BURST adds exactly one cycle of latency.
- A new rd_req can be accepted in the cycle after rd_done, when rd_ack=1.
- Throughput: 1 row per cycle, both write and read, when the two are not concurrent.

## Structure
- Package hotbuf_pkg holds:
  - state_e enum {IDLE, BURST, LAST}
  - default DATA_W/LANES/DEPTH localparams
  - row_t typedef (logic [LANES-1:0][DATA_W-1:0])
- Sub-module hotbuf_mem: single-port DEPTH×row_t array with synchronous write and registered read. It has no reset on the array.
- Top level holds the FSM, the address and remaining counters, and the output register with the stall logic.

## Test plan
- Write rows 0..3 with lane i = row*1000+i. Burst rd_start=0, rd_len=4, out_ready=1 → 4 beats on consecutive cycles, values 0,1000,2000,3000 in lane 0, out_last on beat 4, rd_done coincident with beat 4.
- Burst rd_start=62, rd_len=4 with DEPTH=64 → rows 62,63,0,1 returned.
- Hold out_ready=0 for 3 cycles after the first beat → out_data stable, no beat lost or duplicated, total beats equal rd_len.
- During a burst from row 10 of length 6, assert wr_en to row 13 with new data at the same cycle a read would issue → issue slips one cycle, and beat 4 returns the new row-13 data.
- rd_req with rd_len=0 → no out_valid, rd_done one cycle later. rd_len=64 → 64 beats covering all rows.
- Assert rst low mid-burst → out_valid=0 and FSM in IDLE immediately, no rd_done. Previously written rows remain readable after rst deasserts.
